// File: rtl/seq_mult_signed.sv
// seq_mult_signed
// Iterative radix-2 shift-add multiplier with a start/busy/done handshake.
// Supports unsigned and two's-complement signed operands, selected per
// operation. Signed operations multiply magnitudes, then negate the
// 2*WIDTH-bit result when the operand signs differ.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (clears control and data)
//   start        request a multiplication; accepted in IDLE or DONE
//   signed_mode  1 = two's-complement operands, 0 = unsigned; sampled with start
//   mul_1        multiplicand, sampled with start
//   mul_2        multiplier, sampled with start
//   busy         high while iterating
//   done         one-cycle pulse when product is updated
//   product      registered 2*WIDTH-bit result, held until the next done
module seq_mult_signed #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mul_1,
    input  logic [WIDTH-1:0]     mul_2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    mcand;
    logic [CNT_W-1:0]    cnt;
    logic                neg;

    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  shifted;

    // Magnitude of an operand held in WIDTH unsigned bits. The most negative
    // value maps onto 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (is_signed && v[WIDTH-1])
            return WIDTH'(-sv);
        return v;
    endfunction

    // Applies the result sign; negating zero yields zero.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                      input logic               is_neg);
        logic signed [2*WIDTH-1:0] smag;
        smag = $signed(mag);
        if (is_neg)
            return (2*WIDTH)'(-smag);
        return mag;
    endfunction

    // One iteration: conditional add into the upper half with carry kept in
    // the extra sum bit, then {carry, acc, mplier} shifted right by one.
    always_comb begin
        sum     = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        shifted = {sum, mplier[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= magnitude(mul_1, signed_mode);
                        mplier <= magnitude(mul_2, signed_mode);
                        neg    <= signed_mode & (mul_1[WIDTH-1] ^ mul_2[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= shifted[2*WIDTH-1:WIDTH];
                    mplier <= shifted[WIDTH-1:0];
                    cnt    <= cnt - CNT_W'(1);
                    // Last iteration: the product is taken from this cycle's
                    // shifted value so done follows the final step directly.
                    if (cnt == CNT_W'(1)) begin
                        product <= apply_sign(shifted, neg);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_signed.sv
// Testbench for seq_mult_signed: a WIDTH=8 and a WIDTH=16 instance share the
// clock and reset. Stimulus pushes expected products into per-instance
// queues; monitors pop and compare on every done pulse and check that the
// product holds between results.
module tb_seq_mult_signed;

    logic        clk;
    logic        rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    logic        rst_q;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp8[$];
    string       nm8[$];
    logic [31:0] exp16[$];
    string       nm16[$];

    logic [15:0] last8;
    logic [31:0] last16;

    seq_mult_signed #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .mul_1(a8), .mul_2(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    seq_mult_signed #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .mul_1(a16), .mul_2(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        logic [15:0] e;
        string       n;
        if (rst_q !== 1'b0) begin
            last8 = '0;
        end else if (done8 === 1'b1) begin
            check("busy_with_done8", 32'(busy8), 32'd0);
            if (exp8.size() == 0) begin
                check("done_without_request8", 32'(done8), 32'd0);
            end else begin
                e = exp8.pop_front();
                n = nm8.pop_front();
                check(n, 32'(prod8), 32'(e));
            end
            last8 = prod8;
        end else begin
            check("product_hold8", 32'(prod8), 32'(last8));
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        string       n;
        if (rst_q !== 1'b0) begin
            last16 = '0;
        end else if (done16 === 1'b1) begin
            check("busy_with_done16", 32'(busy16), 32'd0);
            if (exp16.size() == 0) begin
                check("done_without_request16", 32'(done16), 32'd0);
            end else begin
                e = exp16.pop_front();
                n = nm16.pop_front();
                check(n, prod16, e);
            end
            last16 = prod16;
        end else begin
            check("product_hold16", prod16, last16);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one sampling edge; returns just after that edge.
    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e, input string name);
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        exp8.push_back(e);
        nm8.push_back(name);
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0;
    endtask

    task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] e, input string name);
        start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        exp16.push_back(e);
        nm16.push_back(name);
        tick();
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; sm16 = 1'b0;
    endtask

    // n = clock edges from the sampling edge to the done edge; bc = busy cycles seen.
    task automatic wait8(output int n, output int bc);
        n  = 0;
        bc = busy8 ? 1 : 0;
        while (done8 !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (busy8 === 1'b1) bc++;
        end
        if (done8 !== 1'b1) check("timeout8", 32'(done8), 32'd1);
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (done16 !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (done16 !== 1'b1) check("timeout16", 32'(done16), 32'd1);
    endtask

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] e;
        string       name;
    } vec8_t;

    vec8_t tbl[8];

    initial begin
        int n, bc;
        logic [15:0] ra, rb;
        logic        rsm;
        logic signed [31:0] ps;
        logic [31:0] re;

        tbl[0] = '{1'b0, 8'h15, 8'h4B, 16'h0627, "u_15x4b"};
        tbl[1] = '{1'b0, 8'h8D, 8'hC8, 16'h6E28, "u_8dxc8"};
        tbl[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff"};
        tbl[3] = '{1'b0, 8'h00, 8'hFF, 16'h0000, "u_00xff"};
        tbl[4] = '{1'b1, 8'h8D, 8'hC8, 16'h1928, "s_8dxc8"};
        tbl[5] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81, "s_ffx7f"};
        tbl[6] = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_80x80"};
        tbl[7] = '{1'b1, 8'h00, 8'h80, 16'h0000, "s_00x80"};

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        tick();
        tick();
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_product8", 32'(prod8), 32'd0);
        check("reset_busy16", 32'(busy16), 32'd0);
        check("reset_product16", prod16, 32'd0);
        rst = 1'b0;
        tick();

        // Done appears WIDTH+1 cycles after start is raised; busy for WIDTH cycles.
        for (int i = 0; i < 8; i++) begin
            issue8(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].name);
            wait8(n, bc);
            check("latency8", 32'(n + 1), 32'd9);
            check("busy_cycles8", 32'(bc), 32'd8);
            tick();
            tick();
        end

        // Start and operand changes during RUN must be ignored.
        issue8(1'b0, 8'h15, 8'h4B, 16'h0627, "ignore_mid_run");
        tick();
        tick();
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'h80;
        tick();
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait8(n, bc);
        tick();

        // Back-to-back: start raised in the done cycle.
        issue8(1'b1, 8'h8D, 8'hC8, 16'h1928, "b2b_first");
        wait8(n, bc);
        issue8(1'b1, 8'hFF, 8'h7F, 16'hFF81, "b2b_second");
        wait8(n, bc);
        check("b2b_gap8", 32'(n + 1), 32'd9);
        tick();

        // Reset during the fourth RUN cycle aborts the operation.
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "aborted");
        tick();
        tick();
        tick();
        rst = 1'b1;
        exp8.delete();
        nm8.delete();
        tick();
        rst = 1'b0;
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_product8", 32'(prod8), 32'd0);
        repeat (14) tick();
        issue8(1'b0, 8'h8D, 8'hC8, 16'h6E28, "after_abort");
        wait8(n, bc);
        check("after_abort_latency8", 32'(n + 1), 32'd9);
        tick();

        // WIDTH=16 instance.
        issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u16_ffffxffff");
        wait16(n);
        check("latency16", 32'(n + 1), 32'd17);
        tick();
        issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "s16_8000x7fff");
        wait16(n);
        check("latency16_signed", 32'(n + 1), 32'd17);
        tick();

        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rsm = 1'($urandom_range(0, 1));
            ps  = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
            re  = rsm ? 32'(ps) : ({16'h0000, ra} * {16'h0000, rb});
            issue16(rsm, ra, rb, re, rsm ? "rand16_signed" : "rand16_unsigned");
            wait16(n);
        end

        repeat (3) tick();
        check("pending8", 32'(exp8.size()), 32'd0);
        check("pending16", 32'(exp16.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
